sd_cmd_engine: RTL and testbench
================================

# sd_cmd_engine

Parametrised SD command-line controller between the host register interface and the CMD physical layer. It frames 48-bit-class commands (start bits, index, argument) and hands them to the PHY with a strobe/ack handshake, then waits for a short or long response. It checks the response index and runs its own response timeout, with automatic retry. Response class per command index is set by parameter masks instead of fixed index lists.

## Interface
Parameters:
- RESP_W, 128: width of `response` output; must be ≥ 120.
- TIMEOUT_W, 16: width of the response-timeout counter and `timeout_limit`.
- MAX_RETRY, 2: re-issues allowed after a timeout or index error (0 = no retry).
- NO_RESP_MASK, 64'h8011: bit i set means index i has no response (CMD0, CMD4, CMD15).
- LONG_RESP_MASK, 64'h604: bit i set means index i has a 136-bit response (CMD2, CMD9, CMD10).
- NO_IDX_CHK_MASK, 64'h200_0000_0000: bit i set means short response without index check (ACMD41).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- new_command  in  1  start request; sampled only in IDLE.
- cmd_index  in  6  command index.
- cmd_argument  in  32  command argument.
- timeout_enable  in  1  enables the response timeout.
- timeout_limit  in  TIMEOUT_W  response wait limit in cycles.
- busy  out  1  high from acceptance until return to IDLE.
- response  out  RESP_W  captured response payload.
- command_complete  out  1  1-cycle pulse at end of command.
- command_timeout  out  1  1-cycle pulse, final attempt timed out.
- command_index_error  out  1  1-cycle pulse, final attempt index mismatch.
- retry_count  out  $clog2(MAX_RETRY+1)  retries used by current/last command.
- cmd_out  out  40  {2'b01, index, argument} to PHY.
- strobe_out  out  1  command valid to PHY.
- ack_in  in  1  PHY accepted the command.
- idle_out  out  1  high in IDLE.
- cmd_in  in  136  response from PHY.
- strobe_in  in  1  response valid from PHY.
- ack_out  out  1  1-cycle response acknowledge.

## Operation
- States: IDLE, SEND, WAIT_RESP, DONE. All outputs and internal registers are registered.
- IDLE: `idle_out`=1, `busy`=0.
  - When `new_command`=1: latch index and argument, clear `response`, clear `retry_count`, go to SEND.
- SEND: `strobe_out`=1 and `cmd_out` held stable until `ack_in`=1.
  - On `ack_in`, for a no-response index: go to DONE with complete.
  - On `ack_in`, otherwise: clear the timer and go to WAIT_RESP.
- WAIT_RESP: timer increments each cycle and saturates at all-ones.
  - When `strobe_in`=1: pulse `ack_out` and capture the response.
    - Long response: `response[119:0]`=`cmd_in[127:8]`, upper bits 0.
    - Short response: `response[31:0]`=`cmd_in[39:8]`, upper bits 0.
    - Index check (short responses not in NO_IDX_CHK_MASK): error if `cmd_in[45:40]` ≠ latched index.
    - No error: go to DONE.
  - On timeout (`timeout_enable`=1 and timer == `timeout_limit`): treat as failure.
  - On any failure: if `retry_count` < MAX_RETRY, increment it and go to SEND. Otherwise go to DONE with the matching error flag.
- DONE: one cycle. Pulse `command_complete` plus any error flag, then go to IDLE. `response` and `retry_count` hold until the next accepted command.
- `strobe_in` and a timeout in the same cycle: `strobe_in` wins.
- `new_command` outside IDLE is ignored. `cmd_index`/`cmd_argument` changes after acceptance have no effect.
- `timeout_enable`=0: WAIT_RESP waits indefinitely.

## Timing
- Reset values:
  - `state`=IDLE, `idle_out`=1.
  - `busy`, `strobe_out`, `ack_out`, `command_complete`, `command_timeout`, `command_index_error`=0.
  - `cmd_out`, `response`, `retry_count`, timer = 0.
- Reset mid-operation returns to IDLE immediately. No completion pulse is emitted.
- `new_command` in cycle N → `busy`, `strobe_out` high in N+1.
- `ack_in` in cycle M → `strobe_out` low in M+1.
- Timer is 0 in the first WAIT_RESP cycle. Timeout fires in the (L+1)th WAIT_RESP cycle; L=0 times out in the first cycle unless `strobe_in` arrives then.
- `strobe_in` in cycle K → `ack_out` and `response` valid in K+1, completion pulse in K+1, `idle_out` in K+2.

## Structure
- Package `sd_cmd_pkg`:
  - state enum.
  - START_BITS=2'b01.
  - response bit-field offsets (IDX_HI=45, IDX_LO=40, SHORT 39:8, LONG 127:8).
  - default mask constants.
  - function `resp_class(index, masks)` returning NONE/SHORT/LONG/SHORT_NOCHK.
- Sub-module `sd_cmd_timer`: clear, enable, saturating TIMEOUT_W counter, `expired` output comparing against `timeout_limit`.

## Test plan
- CMD0, arg 0, `ack_in` 2 cycles after strobe → `cmd_out`=40'h40_0000_0000. Complete pulse, no errors, `response`=0, total 4 cycles.
- CMD17 arg 32'h1234, `cmd_in[45:40]`=17, `cmd_in[39:8]`=32'hCAFE_F00D → `response`=32'hCAFEF00D, complete pulse, `retry_count`=0.
- CMD2 with `cmd_in[127:8]`=120'hA5…A5 → `response[119:0]` matches, `response[127:120]`=0.
- CMD8, `timeout_limit`=5, no `strobe_in`, MAX_RETRY=2 → three SEND phases, then `command_timeout` pulse with `retry_count`=2.
- CMD3 response with index 5 on first attempt, 3 on retry → `command_index_error` stays 0, `retry_count`=1, complete.
- ACMD41 with mismatched index field → no error. Reset asserted in WAIT_RESP → all outputs at reset values the same cycle.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared types and constants for the SD command engine.
//   state_e        - command FSM states
//   resp_class_e   - response class of a command index
//   START_BITS     - start + transmission bits prefixed to every command
//   IDX_*/SHORT_*/LONG_* - bit-field positions inside the 136-bit PHY response
//   DEF_*_MASK     - default per-index response-class masks
//   resp_class()   - maps an index onto its response class using the masks
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RESP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_SHORT,
    RESP_LONG,
    RESP_SHORT_NOCHK
  } resp_class_e;

  localparam logic [1:0] START_BITS = 2'b01;

  localparam int IDX_HI   = 45;
  localparam int IDX_LO   = 40;
  localparam int SHORT_HI = 39;
  localparam int SHORT_LO = 8;
  localparam int LONG_HI  = 127;
  localparam int LONG_LO  = 8;

  localparam logic [63:0] DEF_NO_RESP_MASK    = 64'h8011;
  localparam logic [63:0] DEF_LONG_RESP_MASK  = 64'h604;
  localparam logic [63:0] DEF_NO_IDX_CHK_MASK = 64'h200_0000_0000;

  // A no-response bit takes precedence over the long bit, which takes
  // precedence over the no-index-check bit.
  function automatic resp_class_e resp_class(input logic [5:0]  index,
                                             input logic [63:0] no_resp_mask,
                                             input logic [63:0] long_mask,
                                             input logic [63:0] no_chk_mask);
    resp_class_e cls;
    if (no_resp_mask[index])     cls = RESP_NONE;
    else if (long_mask[index])   cls = RESP_LONG;
    else if (no_chk_mask[index]) cls = RESP_SHORT_NOCHK;
    else                         cls = RESP_SHORT;
    return cls;
  endfunction

endpackage

// File: rtl/sd_cmd_timer.sv
// sd_cmd_timer: saturating response-wait counter.
//   clock, reset   - clock and asynchronous active-high reset
//   clear          - forces the count to zero (has priority over enable)
//   enable         - advances the count by one, sticking at all-ones
//   timeout_limit  - compare value
//   expired        - count equals timeout_limit
module sd_cmd_timer #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = (count == timeout_limit);

endmodule

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: frames SD commands for the CMD PHY, waits for the response,
// checks its index, and retries on timeout or index mismatch.
//   clock, reset          - clock and asynchronous active-high reset
//   new_command, cmd_index, cmd_argument - host start request (IDLE only)
//   timeout_enable, timeout_limit        - response timeout control
//   busy, idle_out        - engine activity
//   response              - captured response payload (zero-extended)
//   command_complete / command_timeout / command_index_error - end pulses
//   retry_count           - retries used by the current/last command
//   cmd_out, strobe_out, ack_in  - command handshake to the PHY
//   cmd_in, strobe_in, ack_out   - response handshake from the PHY
module sd_cmd_engine
  import sd_cmd_pkg::*;
#(
  parameter int          RESP_W          = 128,
  parameter int          TIMEOUT_W       = 16,
  parameter int          MAX_RETRY       = 2,
  parameter logic [63:0] NO_RESP_MASK    = DEF_NO_RESP_MASK,
  parameter logic [63:0] LONG_RESP_MASK  = DEF_LONG_RESP_MASK,
  parameter logic [63:0] NO_IDX_CHK_MASK = DEF_NO_IDX_CHK_MASK,
  localparam int         RC_W            = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 new_command,
  input  logic [5:0]           cmd_index,
  input  logic [31:0]          cmd_argument,
  input  logic                 timeout_enable,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 busy,
  output logic [RESP_W-1:0]    response,
  output logic                 command_complete,
  output logic                 command_timeout,
  output logic                 command_index_error,
  output logic [RC_W-1:0]      retry_count,
  output logic [39:0]          cmd_out,
  output logic                 strobe_out,
  input  logic                 ack_in,
  output logic                 idle_out,
  input  logic [135:0]         cmd_in,
  input  logic                 strobe_in,
  output logic                 ack_out
);

  state_e      state;
  resp_class_e cls_q;
  logic [5:0]  index_q;

  logic timer_expired;
  logic idx_mismatch;
  logic timed_out;
  logic retry_ok;

  // CRC, end bit and the reserved top byte are handled by the PHY.
  logic unused_cmd_in;
  assign unused_cmd_in = ^{cmd_in[135:128], cmd_in[7:0]};

  // The timer is held at zero outside WAIT_RESP, so it always enters a
  // wait (first attempt or retry) at zero.
  sd_cmd_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clock         (clock),
    .reset         (reset),
    .clear         (state != S_WAIT_RESP),
    .enable        (state == S_WAIT_RESP),
    .timeout_limit (timeout_limit),
    .expired       (timer_expired)
  );

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_mismatch = 1'b0;
    if (cls_q == RESP_SHORT) begin
      idx_mismatch = (cmd_in[IDX_HI:IDX_LO] != index_q);
    end
    timed_out = timeout_enable && timer_expired;
    retry_ok  = int'(retry_count) < MAX_RETRY;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      cls_q               <= RESP_NONE;
      index_q             <= '0;
      idle_out            <= 1'b1;
      busy                <= 1'b0;
      strobe_out          <= 1'b0;
      ack_out             <= 1'b0;
      command_complete    <= 1'b0;
      command_timeout     <= 1'b0;
      command_index_error <= 1'b0;
      cmd_out             <= '0;
      response            <= '0;
      retry_count         <= '0;
    end else begin
      // Pulse outputs default low; the branches below raise them for one cycle.
      ack_out             <= 1'b0;
      command_complete    <= 1'b0;
      command_timeout     <= 1'b0;
      command_index_error <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (new_command) begin
            index_q     <= cmd_index;
            cls_q       <= resp_class(cmd_index, NO_RESP_MASK, LONG_RESP_MASK,
                                      NO_IDX_CHK_MASK);
            cmd_out     <= {START_BITS, cmd_index, cmd_argument};
            response    <= '0;
            retry_count <= '0;
            idle_out    <= 1'b0;
            busy        <= 1'b1;
            strobe_out  <= 1'b1;
            state       <= S_SEND;
          end
        end

        S_SEND: begin
          if (ack_in) begin
            strobe_out <= 1'b0;
            if (cls_q == RESP_NONE) begin
              command_complete <= 1'b1;
              state            <= S_DONE;
            end else begin
              state <= S_WAIT_RESP;
            end
          end
        end

        S_WAIT_RESP: begin
          // The response is captured even when its index turns out wrong.
          if (strobe_in) begin
            ack_out <= 1'b1;
            if (cls_q == RESP_LONG) response <= RESP_W'(cmd_in[LONG_HI:LONG_LO]);
            else                    response <= RESP_W'(cmd_in[SHORT_HI:SHORT_LO]);
          end

          // A response arriving in the timeout cycle wins over the timeout.
          if (strobe_in && !idx_mismatch) begin
            command_complete <= 1'b1;
            state            <= S_DONE;
          end else if (strobe_in || timed_out) begin
            if (retry_ok) begin
              retry_count <= retry_count + RC_W'(1);
              strobe_out  <= 1'b1;
              state       <= S_SEND;
            end else begin
              command_complete    <= 1'b1;
              command_timeout     <= !strobe_in;
              command_index_error <= strobe_in;
              state               <= S_DONE;
            end
          end
        end

        S_DONE: begin
          busy     <= 1'b0;
          idle_out <= 1'b1;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: directed stimulus with a completion scoreboard. The
// stimulus thread plays both host and PHY; each command pushes its expected
// completion record, and a monitor pops and compares it whenever the engine
// pulses command_complete.
module tb_sd_cmd_engine;

  logic         clock = 1'b0;
  logic         reset;
  logic         new_command;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic         timeout_enable;
  logic [15:0]  timeout_limit;
  logic         busy;
  logic [127:0] response;
  logic         command_complete;
  logic         command_timeout;
  logic         command_index_error;
  logic [1:0]   retry_count;
  logic [39:0]  cmd_out;
  logic         strobe_out;
  logic         ack_in;
  logic         idle_out;
  logic [135:0] cmd_in;
  logic         strobe_in;
  logic         ack_out;

  sd_cmd_engine dut (
    .clock               (clock),
    .reset               (reset),
    .new_command         (new_command),
    .cmd_index           (cmd_index),
    .cmd_argument        (cmd_argument),
    .timeout_enable      (timeout_enable),
    .timeout_limit       (timeout_limit),
    .busy                (busy),
    .response            (response),
    .command_complete    (command_complete),
    .command_timeout     (command_timeout),
    .command_index_error (command_index_error),
    .retry_count         (retry_count),
    .cmd_out             (cmd_out),
    .strobe_out          (strobe_out),
    .ack_in              (ack_in),
    .idle_out            (idle_out),
    .cmd_in              (cmd_in),
    .strobe_in           (strobe_in),
    .ack_out             (ack_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] resp;
    logic         to;
    logic         ie;
    logic [1:0]   rc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   busy_cycles = 0;

  task automatic check(input string name, input logic [135:0] act,
                       input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic [127:0] resp, input logic to,
                             input logic ie, input logic [1:0] rc);
    exp_t e;
    e.resp = resp;
    e.to   = to;
    e.ie   = ie;
    e.rc   = rc;
    sb_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per completion pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if ((command_timeout || command_index_error) && !command_complete)
          check("error_without_complete", command_complete, 1'b1);
        if (command_complete) begin
          if (sb_q.size() == 0) begin
            check("unexpected_complete", command_complete, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check("response",        response,            e.resp);
            check("timeout_flag",    command_timeout,     e.to);
            check("index_err_flag",  command_index_error, e.ie);
            check("retry_count",     retry_count,         e.rc);
          end
        end
      end
    end
  end

  always @(negedge clock) if (busy) busy_cycles++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg);
    cmd_index    = idx;
    cmd_argument = arg;
    new_command  = 1'b1;
    tick();
    new_command  = 1'b0;
    cmd_index    = ~idx;
    cmd_argument = ~arg;
    check("busy_after_accept",   busy,       1'b1);
    check("strobe_after_accept", strobe_out, 1'b1);
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (!strobe_out && n < 64) begin
      tick();
      n++;
    end
    check("strobe_seen", strobe_out, 1'b1);
  endtask

  // Waits for the strobe, holds `hold` extra cycles, then acks for one cycle.
  task automatic send_phase(input logic [39:0] exp_cmd, input int hold);
    wait_strobe();
    tick(hold);
    check("cmd_out", cmd_out, exp_cmd);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    check("strobe_drop", strobe_out, 1'b0);
  endtask

  task automatic respond(input logic [135:0] v);
    cmd_in    = v;
    strobe_in = 1'b1;
    tick();
    strobe_in = 1'b0;
    check("ack_out", ack_out, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle_out && n < 64) begin
      tick();
      n++;
    end
    check("idle_reached", idle_out, 1'b1);
  endtask

  // Junk ones outside the decoded fields must not leak into `response`.
  function automatic logic [135:0] short_resp(input logic [5:0] idx,
                                              input logic [31:0] data);
    logic [135:0] v;
    v         = '1;
    v[45:40]  = idx;
    v[39:8]   = data;
    return v;
  endfunction

  function automatic logic [135:0] long_resp(input logic [119:0] payload);
    logic [135:0] v;
    v         = '1;
    v[127:8]  = payload;
    return v;
  endfunction

  initial begin
    int n;
    logic [119:0] pat;

    reset          = 1'b1;
    new_command    = 1'b0;
    cmd_index      = '0;
    cmd_argument   = '0;
    timeout_enable = 1'b1;
    timeout_limit  = 16'd100;
    ack_in         = 1'b0;
    cmd_in         = '0;
    strobe_in      = 1'b0;
    tick(2);

    check("rst_idle_out",   idle_out,         1'b1);
    check("rst_busy",       busy,             1'b0);
    check("rst_strobe_out", strobe_out,       1'b0);
    check("rst_ack_out",    ack_out,          1'b0);
    check("rst_complete",   command_complete, 1'b0);
    check("rst_cmd_out",    cmd_out,          40'h0);
    check("rst_response",   response,         128'h0);
    check("rst_retry",      retry_count,      2'd0);
    reset = 1'b0;
    tick();

    // CMD0: no response, ack two cycles after the strobe appears.
    expect_done(128'h0, 1'b0, 1'b0, 2'd0);
    busy_cycles = 0;
    issue(6'd0, 32'h0);
    send_phase(40'h40_0000_0000, 2);
    wait_idle();
    check("cmd0_busy_cycles", busy_cycles, 4);

    // CMD17: short response; a new_command pulse while waiting is ignored.
    expect_done(128'hCAFE_F00D, 1'b0, 1'b0, 2'd0);
    issue(6'd17, 32'h1234);
    send_phase(40'h51_0000_1234, 0);
    tick(3);
    cmd_index   = 6'd0;
    new_command = 1'b1;
    tick();
    new_command = 1'b0;
    check("busy_while_waiting", busy, 1'b1);
    respond(short_resp(6'd17, 32'hCAFE_F00D));
    tick();
    check("idle_k_plus_2", idle_out, 1'b1);
    tick(2);
    check("stays_idle", idle_out, 1'b1);
    check("response_hold", response, 128'hCAFE_F00D);

    // CMD2: long response, top byte zero-filled.
    pat = {15{8'hA5}};
    expect_done({8'h00, pat}, 1'b0, 1'b0, 2'd0);
    issue(6'd2, 32'h0);
    send_phase(40'h42_0000_0000, 1);
    tick(2);
    respond(long_resp(pat));
    wait_idle();

    // CMD8: no response ever; three sends, then final timeout.
    timeout_limit = 16'd5;
    expect_done(128'h0, 1'b1, 1'b0, 2'd2);
    issue(6'd8, 32'h1AA);
    for (int a = 0; a < 3; a++) begin
      send_phase(40'h48_0000_01AA, 0);
      n = 1;
      while (!strobe_out && !command_complete && n < 64) begin
        tick();
        n++;
      end
      check("timeout_latency", n, 7);
    end
    wait_idle();

    // CMD3: wrong index on the first attempt, correct on the retry.
    timeout_limit = 16'd100;
    expect_done(128'h0606_0606, 1'b0, 1'b0, 2'd1);
    issue(6'd3, 32'h0);
    send_phase(40'h43_0000_0000, 0);
    tick();
    respond(short_resp(6'd5, 32'h1111_2222));
    check("retry_strobe",    strobe_out,  1'b1);
    check("retry_count_mid", retry_count, 2'd1);
    send_phase(40'h43_0000_0000, 0);
    respond(short_resp(6'd3, 32'h0606_0606));
    wait_idle();

    // CMD3: wrong index on every attempt.
    expect_done(128'h3333_4444, 1'b0, 1'b1, 2'd2);
    issue(6'd3, 32'h0);
    for (int a = 0; a < 3; a++) begin
      send_phase(40'h43_0000_0000, 0);
      respond(short_resp(6'd7, (a == 2) ? 32'h3333_4444 : 32'hDEAD_0000));
    end
    wait_idle();

    // ACMD41: index field is not checked.
    expect_done(128'h80FF_8000, 1'b0, 1'b0, 2'd0);
    issue(6'd41, 32'h40FF_8000);
    send_phase(40'h69_40FF_8000, 0);
    respond(short_resp(6'h3F, 32'h80FF_8000));
    wait_idle();

    // Timeout disabled: a small limit must not fire.
    timeout_enable = 1'b0;
    timeout_limit  = 16'd2;
    expect_done(128'h5A5A_0001, 1'b0, 1'b0, 2'd0);
    issue(6'd17, 32'h1);
    send_phase(40'h51_0000_0001, 0);
    tick(20);
    check("no_timeout_strobe", strobe_out, 1'b0);
    check("no_timeout_busy",   busy,       1'b1);
    respond(short_resp(6'd17, 32'h5A5A_0001));
    wait_idle();
    timeout_enable = 1'b1;

    // Limit 0: response in the first wait cycle beats the timeout.
    timeout_limit = 16'd0;
    expect_done(128'h0BAD_BEEF, 1'b0, 1'b0, 2'd0);
    issue(6'd17, 32'h2);
    send_phase(40'h51_0000_0002, 0);
    respond(short_resp(6'd17, 32'h0BAD_BEEF));
    wait_idle();

    // Reset while waiting: outputs return to reset values at once.
    timeout_limit = 16'd100;
    issue(6'd17, 32'h3);
    send_phase(40'h51_0000_0003, 0);
    tick(2);
    reset = 1'b1;
    #1;
    check("mid_rst_idle_out", idle_out,    1'b1);
    check("mid_rst_busy",     busy,        1'b0);
    check("mid_rst_strobe",   strobe_out,  1'b0);
    check("mid_rst_ack_out",  ack_out,     1'b0);
    check("mid_rst_cmd_out",  cmd_out,     40'h0);
    check("mid_rst_response", response,    128'h0);
    check("mid_rst_retry",    retry_count, 2'd0);
    tick();
    reset = 1'b0;
    tick(3);
    check("post_rst_idle", idle_out, 1'b1);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
